mem_arbiter: RTL and testbench

- Shares the single physical-memory port between the instruction cache and the data cache of the pipelined LC-3b core.
- Selects one requester per transaction and passes its request through to pmem.
- Routes pmem_resp back to the granted requester only.
- Exposes its grant as a 2-bit select in the same encoding as the datapath 3-input muxes: 00 none, 01 I-cache, 10 D-cache.

---
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single physical-memory port between the LC-3b
// I-cache and D-cache. One requester is granted per transaction, its request
// is passed straight through to pmem, and pmem_resp is routed back to the
// granted side only. Ties are broken round-robin against the last grant, and
// every transaction is followed by at least one IDLE cycle.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset_n,
  // I-cache side
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  // D-cache side
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  // physical memory side
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp,
  // grant select, same encoding as the datapath 3-input muxes
  output logic [1:0]            arb_sel
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SERVE_I = 2'b01,
    SERVE_D = 2'b10
  } state_t;

  // Grant encoding; also the value held in the last-grant register.
  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_t r_state;
  state_t w_stateNext;
  logic   r_lastGrant;
  logic   w_lastGrantNext;

  logic   w_iReq;
  logic   w_dReq;

  assign w_iReq = i_read;
  assign w_dReq = d_read | d_write;

  // Read data is broadcast to both caches; only the resp lines qualify it.
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

  // State and last-grant registers; reset leaves last grant at D so the
  // first tie after reset goes to the I-cache.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_lastGrant <= GRANT_D;
    end else begin
      r_state     <= w_stateNext;
      r_lastGrant <= w_lastGrantNext;
    end
  end

  // Next-state logic: arbitrate in IDLE, hold a grant until pmem responds.
  always_comb begin
    w_stateNext     = r_state;
    w_lastGrantNext = r_lastGrant;
    unique case (r_state)
      IDLE: begin
        if (w_iReq && w_dReq) begin
          w_stateNext = (r_lastGrant == GRANT_D) ? SERVE_I : SERVE_D;
        end else if (w_iReq) begin
          w_stateNext = SERVE_I;
        end else if (w_dReq) begin
          w_stateNext = SERVE_D;
        end
      end
      SERVE_I: begin
        if (pmem_resp) begin
          w_stateNext     = IDLE;
          w_lastGrantNext = GRANT_I;
        end
      end
      SERVE_D: begin
        if (pmem_resp) begin
          w_stateNext     = IDLE;
          w_lastGrantNext = GRANT_D;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // Output steering: pass the granted requester through to pmem and return
  // pmem_resp to it in the same cycle. A stray resp in IDLE goes nowhere.
  always_comb begin
    arb_sel      = 2'b00;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_resp       = 1'b0;
    d_resp       = 1'b0;
    unique case (r_state)
      IDLE: begin
        arb_sel = 2'b00;
      end
      SERVE_I: begin
        arb_sel      = 2'b01;
        pmem_read    = i_read;
        pmem_address = i_address;
        i_resp       = pmem_resp;
      end
      SERVE_D: begin
        arb_sel      = 2'b10;
        pmem_read    = d_read & ~d_write;
        pmem_write   = d_write;
        pmem_address = d_address;
        pmem_wdata   = d_wdata;
        d_resp       = pmem_resp;
      end
      default: begin
        arb_sel = 2'b00;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed-vector bench for mem_arbiter. Inputs change 1ns
// after each rising edge; outputs are checked 1ns later, well clear of edges.
module tb_mem_arbiter;

  localparam int ADDR_WIDTH = 16;
  localparam int LINE_WIDTH = 128;

  logic                  clk;
  logic                  reset_n;
  logic                  i_read;
  logic [ADDR_WIDTH-1:0] i_address;
  logic [LINE_WIDTH-1:0] i_rdata;
  logic                  i_resp;
  logic                  d_read;
  logic                  d_write;
  logic [ADDR_WIDTH-1:0] d_address;
  logic [LINE_WIDTH-1:0] d_wdata;
  logic [LINE_WIDTH-1:0] d_rdata;
  logic                  d_resp;
  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic [LINE_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;
  logic [1:0]            arb_sel;

  int checkCount = 0;
  int passCount  = 0;

  localparam logic [LINE_WIDTH-1:0] RDATA_A = 128'hDEADBEEF_00000000_00000000_00000001;
  localparam logic [LINE_WIDTH-1:0] RDATA_B = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [LINE_WIDTH-1:0] WDATA_5 = {32{4'h5}};
  localparam logic [LINE_WIDTH-1:0] WDATA_A = {32{4'hA}};

  mem_arbiter #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .LINE_WIDTH(LINE_WIDTH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_read      (i_read),
    .i_address   (i_address),
    .i_rdata     (i_rdata),
    .i_resp      (i_resp),
    .d_read      (d_read),
    .d_write     (d_write),
    .d_address   (d_address),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .d_resp      (d_resp),
    .pmem_read   (pmem_read),
    .pmem_write  (pmem_write),
    .pmem_address(pmem_address),
    .pmem_wdata  (pmem_wdata),
    .pmem_rdata  (pmem_rdata),
    .pmem_resp   (pmem_resp),
    .arb_sel     (arb_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [LINE_WIDTH-1:0] actual,
                             input logic [LINE_WIDTH-1:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge, where inputs may change.
  task automatic applyStimulus;
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle;
    #1;
  endtask

  // One arbitrated transaction with both requesters held: one cycle in the
  // serve state, then pmem responds, then the mandatory IDLE cycle.
  task automatic serveOne(input string tag, input logic [1:0] expSel,
                          input logic [LINE_WIDTH-1:0] rdata);
    applyStimulus;
    settle;
    checkOutput({tag, " sel"}, LINE_WIDTH'(arb_sel), LINE_WIDTH'(expSel));
    pmem_resp  = 1'b1;
    pmem_rdata = rdata;
    settle;
    checkOutput({tag, " i_resp"}, LINE_WIDTH'(i_resp), LINE_WIDTH'(expSel == 2'b01));
    checkOutput({tag, " d_resp"}, LINE_WIDTH'(d_resp), LINE_WIDTH'(expSel == 2'b10));
    applyStimulus;
    pmem_resp = 1'b0;
    settle;
    checkOutput({tag, " turnaround sel"}, LINE_WIDTH'(arb_sel), '0);
  endtask

  initial begin
    reset_n    = 1'b0;
    i_read     = 1'b1;
    i_address  = 16'h1230;
    d_read     = 1'b0;
    d_write    = 1'b0;
    d_address  = '0;
    d_wdata    = '0;
    pmem_rdata = '0;
    pmem_resp  = 1'b0;

    // Reset held with an I request pending: everything quiet.
    applyStimulus;
    applyStimulus;
    settle;
    checkOutput("reset arb_sel", LINE_WIDTH'(arb_sel), '0);
    checkOutput("reset pmem_read", LINE_WIDTH'(pmem_read), '0);
    checkOutput("reset pmem_address", LINE_WIDTH'(pmem_address), '0);
    checkOutput("reset i_resp", LINE_WIDTH'(i_resp), '0);

    // Release between edges; still IDLE until the next edge samples i_read.
    reset_n = 1'b1;
    settle;
    checkOutput("post-release idle sel", LINE_WIDTH'(arb_sel), '0);
    applyStimulus;
    settle;
    checkOutput("I grant sel", LINE_WIDTH'(arb_sel), LINE_WIDTH'(2'b01));
    checkOutput("I pmem_read", LINE_WIDTH'(pmem_read), LINE_WIDTH'(1'b1));
    checkOutput("I pmem_write", LINE_WIDTH'(pmem_write), '0);
    checkOutput("I pmem_address", LINE_WIDTH'(pmem_address), LINE_WIDTH'(16'h1230));

    // Memory takes several cycles; no resp until it answers.
    for (int k = 0; k < 4; k++) applyStimulus;
    settle;
    checkOutput("I waiting i_resp", LINE_WIDTH'(i_resp), '0);
    checkOutput("I waiting sel", LINE_WIDTH'(arb_sel), LINE_WIDTH'(2'b01));
    pmem_resp  = 1'b1;
    pmem_rdata = RDATA_A;
    settle;
    checkOutput("I i_resp", LINE_WIDTH'(i_resp), LINE_WIDTH'(1'b1));
    checkOutput("I d_resp", LINE_WIDTH'(d_resp), '0);
    checkOutput("I i_rdata", i_rdata, RDATA_A);
    checkOutput("I d_rdata broadcast", d_rdata, RDATA_A);
    applyStimulus;
    pmem_resp = 1'b0;
    i_read    = 1'b0;
    settle;
    checkOutput("I done sel", LINE_WIDTH'(arb_sel), '0);
    checkOutput("I done i_resp", LINE_WIDTH'(i_resp), '0);
    checkOutput("I done pmem_read", LINE_WIDTH'(pmem_read), '0);

    // D-cache writeback.
    d_write   = 1'b1;
    d_address = 16'h4A70;
    d_wdata   = WDATA_5;
    applyStimulus;
    settle;
    checkOutput("D sel", LINE_WIDTH'(arb_sel), LINE_WIDTH'(2'b10));
    checkOutput("D pmem_write", LINE_WIDTH'(pmem_write), LINE_WIDTH'(1'b1));
    checkOutput("D pmem_read", LINE_WIDTH'(pmem_read), '0);
    checkOutput("D pmem_address", LINE_WIDTH'(pmem_address), LINE_WIDTH'(16'h4A70));
    checkOutput("D pmem_wdata", pmem_wdata, WDATA_5);
    applyStimulus;
    settle;
    checkOutput("D waiting d_resp", LINE_WIDTH'(d_resp), '0);
    pmem_resp = 1'b1;
    settle;
    checkOutput("D d_resp", LINE_WIDTH'(d_resp), LINE_WIDTH'(1'b1));
    checkOutput("D i_resp", LINE_WIDTH'(i_resp), '0);
    applyStimulus;
    pmem_resp = 1'b0;
    d_write   = 1'b0;
    d_wdata   = '0;
    settle;
    checkOutput("D done d_resp", LINE_WIDTH'(d_resp), '0);
    checkOutput("D done pmem_write", LINE_WIDTH'(pmem_write), '0);

    // Both requesting continuously: last grant was D, so I, D, I, D.
    i_read    = 1'b1;
    i_address = 16'h0100;
    d_read    = 1'b1;
    d_address = 16'h0200;
    serveOne("rr1 I", 2'b01, RDATA_B);
    serveOne("rr2 D", 2'b10, RDATA_A);
    serveOne("rr3 I", 2'b01, RDATA_B);
    serveOne("rr4 D", 2'b10, RDATA_A);
    i_read = 1'b0;

    // Read and write together is a violation; the write wins.
    d_write = 1'b1;
    d_wdata = WDATA_A;
    applyStimulus;
    settle;
    checkOutput("rw pmem_write", LINE_WIDTH'(pmem_write), LINE_WIDTH'(1'b1));
    checkOutput("rw pmem_read", LINE_WIDTH'(pmem_read), '0);

    // Dropped request: strobes follow the inputs but the grant holds.
    d_read  = 1'b0;
    d_write = 1'b0;
    settle;
    checkOutput("drop pmem_write", LINE_WIDTH'(pmem_write), '0);
    applyStimulus;
    settle;
    checkOutput("drop sel held", LINE_WIDTH'(arb_sel), LINE_WIDTH'(2'b10));

    // Reset mid-transaction: strobe vanishes before the next edge, no resp.
    d_write = 1'b1;
    settle;
    checkOutput("pre-reset pmem_write", LINE_WIDTH'(pmem_write), LINE_WIDTH'(1'b1));
    reset_n   = 1'b0;
    pmem_resp = 1'b1;
    settle;
    checkOutput("async reset pmem_write", LINE_WIDTH'(pmem_write), '0);
    checkOutput("async reset sel", LINE_WIDTH'(arb_sel), '0);
    checkOutput("async reset d_resp", LINE_WIDTH'(d_resp), '0);
    d_write   = 1'b0;
    pmem_resp = 1'b0;
    applyStimulus;
    reset_n = 1'b1;
    applyStimulus;
    settle;
    checkOutput("after reset sel", LINE_WIDTH'(arb_sel), '0);

    // Stray pmem_resp while IDLE is ignored and does not move the state.
    pmem_resp = 1'b1;
    settle;
    checkOutput("stray i_resp", LINE_WIDTH'(i_resp), '0);
    checkOutput("stray d_resp", LINE_WIDTH'(d_resp), '0);
    applyStimulus;
    pmem_resp = 1'b0;
    settle;
    checkOutput("stray sel", LINE_WIDTH'(arb_sel), '0);

    // After the reset, last grant is D again: a tie goes to I first.
    i_read = 1'b1;
    d_read = 1'b1;
    serveOne("post-reset tie I", 2'b01, RDATA_B);
    i_read = 1'b0;
    d_read = 1'b0;

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
